// File: rtl/alu_issue_ctrl_pkg.sv
// Shared definitions for the ALU issue controller: FSM states, ALUCtrl codes,
// LEGv8 opcode patterns/masks and a masked opcode-compare helper.
package alu_issue_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   localparam logic [3:0] ALU_AND   = 4'b0000;
   localparam logic [3:0] ALU_ORR   = 4'b0001;
   localparam logic [3:0] ALU_ADD   = 4'b0010;
   localparam logic [3:0] ALU_SUB   = 4'b0110;
   localparam logic [3:0] ALU_PASSB = 4'b0111;

   localparam logic [10:0] OP_ADD  = 11'b10001011000;
   localparam logic [10:0] OP_SUB  = 11'b11001011000;
   localparam logic [10:0] OP_AND  = 11'b10001010000;
   localparam logic [10:0] OP_ORR  = 11'b10101010000;
   localparam logic [10:0] OP_ADDI = 11'b10010001000;
   localparam logic [10:0] OP_SUBI = 11'b11010001000;
   localparam logic [10:0] OP_LDUR = 11'b11111000010;
   localparam logic [10:0] OP_STUR = 11'b11111000000;
   localparam logic [10:0] OP_CBZ  = 11'b10110100000;

   // Immediate forms ignore bit 0, CBZ ignores the low three bits.
   localparam logic [10:0] MASK_FULL = 11'b11111111111;
   localparam logic [10:0] MASK_IMM  = 11'b11111111110;
   localparam logic [10:0] MASK_CB   = 11'b11111111000;

   function automatic logic op_match(input logic [10:0] op,
                                     input logic [10:0] pat,
                                     input logic [10:0] mask);
      return ((op & mask) == (pat & mask));
   endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational LEGv8 opcode decoder: Opcode[10:0] -> {illegal, ALUCtrl}.
module alu_op_decode
   import alu_issue_ctrl_pkg::*;
(
   input  logic [10:0] opcode,
   output logic        illegal,
   output logic [3:0]  alu_ctrl
);

   // Priority match of the opcode against the supported instruction patterns
   always_comb begin
      illegal  = 1'b0;
      alu_ctrl = ALU_AND;
      if (op_match(opcode, OP_ADD, MASK_FULL)) begin
         alu_ctrl = ALU_ADD;
      end else if (op_match(opcode, OP_SUB, MASK_FULL)) begin
         alu_ctrl = ALU_SUB;
      end else if (op_match(opcode, OP_AND, MASK_FULL)) begin
         alu_ctrl = ALU_AND;
      end else if (op_match(opcode, OP_ORR, MASK_FULL)) begin
         alu_ctrl = ALU_ORR;
      end else if (op_match(opcode, OP_ADDI, MASK_IMM)) begin
         alu_ctrl = ALU_ADD;
      end else if (op_match(opcode, OP_SUBI, MASK_IMM)) begin
         alu_ctrl = ALU_SUB;
      end else if (op_match(opcode, OP_LDUR, MASK_FULL) ||
                   op_match(opcode, OP_STUR, MASK_FULL)) begin
         alu_ctrl = ALU_ADD;
      end else if (op_match(opcode, OP_CBZ, MASK_CB)) begin
         alu_ctrl = ALU_PASSB;
      end else begin
         illegal  = 1'b1;
         alu_ctrl = ALU_AND;
      end
   end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Initiator side of the ALU interface: accepts an instruction, drives the
// combinational ALU, waits SETTLE cycles, captures BusW and returns the result.
module alu_issue_ctrl
   import alu_issue_ctrl_pkg::*;
#(
   parameter int WIDTH  = 64,
   parameter int SETTLE = 1,
   parameter int CNTW   = 16
) (
   input  logic             CLK,
   input  logic             Reset_L,
   input  logic             InValid,
   output logic             InReady,
   input  logic [10:0]      Opcode,
   input  logic [WIDTH-1:0] OpA,
   input  logic [WIDTH-1:0] OpB,
   output logic [3:0]       ALUCtrl,
   output logic [WIDTH-1:0] BusA,
   output logic [WIDTH-1:0] BusB,
   input  logic [WIDTH-1:0] BusW,
   output logic             OutValid,
   input  logic             OutReady,
   output logic [WIDTH-1:0] Result,
   output logic             ZeroFlag,
   output logic             Illegal,
   output logic [CNTW-1:0]  OpCount
);

   localparam int SCW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

   state_t         state_r;
   logic [SCW-1:0] settle_r;
   logic           dec_illegal_s;
   logic [3:0]     dec_ctrl_s;

   alu_op_decode u_decode (
      .opcode   (Opcode),
      .illegal  (dec_illegal_s),
      .alu_ctrl (dec_ctrl_s)
   );

   assign InReady  = (state_r == ST_IDLE) & Reset_L;
   assign OutValid = (state_r == ST_RESP);

   // Issue FSM with settle counter, ALU bus registers, capture and op counter
   always_ff @(posedge CLK or negedge Reset_L) begin
      if (!Reset_L) begin
         state_r  <= ST_IDLE;
         settle_r <= '0;
         ALUCtrl  <= 4'b0000;
         BusA     <= '0;
         BusB     <= '0;
         Result   <= '0;
         ZeroFlag <= 1'b0;
         Illegal  <= 1'b0;
         OpCount  <= '0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (InValid) begin
                  if (dec_illegal_s) begin
                     // No ALU issue: buses keep the last legal operation
                     Result   <= '0;
                     ZeroFlag <= 1'b0;
                     Illegal  <= 1'b1;
                     state_r  <= ST_RESP;
                  end else begin
                     BusA     <= OpA;
                     BusB     <= OpB;
                     ALUCtrl  <= dec_ctrl_s;
                     settle_r <= SCW'(SETTLE - 1);
                     state_r  <= ST_EXEC;
                  end
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_EXEC: begin
               if (settle_r != '0) begin
                  settle_r <= settle_r - SCW'(1);
               end else begin
                  Result   <= BusW;
                  ZeroFlag <= (BusW == '0);
                  Illegal  <= 1'b0;
                  state_r  <= ST_RESP;
               end
            end
            ST_RESP: begin
               if (OutReady) begin
                  OpCount <= OpCount + CNTW'(1);
                  state_r <= ST_IDLE;
               end else begin
                  state_r <= ST_RESP;
               end
            end
            default: begin
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench: two controllers (SETTLE=1 and SETTLE=3), each driving
// a behavioural combinational ALU, checked through an expected-result queue.
module tb_alu_issue_ctrl;

   typedef struct {
      logic [63:0] res;
      logic        zero;
      logic        ill;
      logic [3:0]  ctrl;
      logic [63:0] bus_a;
      logic [63:0] bus_b;
      int          lat;
   } exp_t;

   logic        clk;
   logic        rst_n     [2];
   logic        in_valid  [2];
   logic        in_ready  [2];
   logic [10:0] opcode    [2];
   logic [63:0] op_a      [2];
   logic [63:0] op_b      [2];
   logic [3:0]  alu_ctrl  [2];
   logic [63:0] bus_a     [2];
   logic [63:0] bus_b     [2];
   logic [63:0] bus_w     [2];
   logic        out_valid [2];
   logic        out_ready [2];
   logic [63:0] result    [2];
   logic        zero_flag [2];
   logic        illegal   [2];
   logic [15:0] op_count  [2];

   int          n_tests = 0;
   int          n_fail  = 0;
   exp_t        sb[$];
   int          exp_cnt   [2];
   logic [3:0]  last_ctrl [2];
   logic [63:0] last_a    [2];
   logic [63:0] last_b    [2];

   alu_issue_ctrl #(.WIDTH(64), .SETTLE(1), .CNTW(16)) u_dut0 (
      .CLK(clk), .Reset_L(rst_n[0]), .InValid(in_valid[0]), .InReady(in_ready[0]),
      .Opcode(opcode[0]), .OpA(op_a[0]), .OpB(op_b[0]), .ALUCtrl(alu_ctrl[0]),
      .BusA(bus_a[0]), .BusB(bus_b[0]), .BusW(bus_w[0]), .OutValid(out_valid[0]),
      .OutReady(out_ready[0]), .Result(result[0]), .ZeroFlag(zero_flag[0]),
      .Illegal(illegal[0]), .OpCount(op_count[0])
   );

   alu_issue_ctrl #(.WIDTH(64), .SETTLE(3), .CNTW(16)) u_dut1 (
      .CLK(clk), .Reset_L(rst_n[1]), .InValid(in_valid[1]), .InReady(in_ready[1]),
      .Opcode(opcode[1]), .OpA(op_a[1]), .OpB(op_b[1]), .ALUCtrl(alu_ctrl[1]),
      .BusA(bus_a[1]), .BusB(bus_b[1]), .BusW(bus_w[1]), .OutValid(out_valid[1]),
      .OutReady(out_ready[1]), .Result(result[1]), .ZeroFlag(zero_flag[1]),
      .Illegal(illegal[1]), .OpCount(op_count[1])
   );

   function automatic logic [63:0] alu_f(input logic [63:0] a, input logic [63:0] b,
                                         input logic [3:0] c);
      case (c)
         4'b0000: return a & b;
         4'b0001: return a | b;
         4'b0010: return a + b;
         4'b0110: return a - b;
         4'b0111: return b;
         default: return 64'd0;
      endcase
   endfunction

   always_comb bus_w[0] = alu_f(bus_a[0], bus_b[0], alu_ctrl[0]);
   always_comb bus_w[1] = alu_f(bus_a[1], bus_b[1], alu_ctrl[1]);

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic exp_t ref_model(input logic [10:0] op, input logic [63:0] a,
                                      input logic [63:0] b);
      exp_t e;
      e.ill = 1'b0; e.ctrl = 4'b0000; e.res = 64'd0;
      e.bus_a = a; e.bus_b = b; e.lat = 0; e.zero = 1'b0;
      casez (op)
         11'b10001011000: begin e.ctrl = 4'b0010; e.res = a + b; end
         11'b11001011000: begin e.ctrl = 4'b0110; e.res = a - b; end
         11'b10001010000: begin e.ctrl = 4'b0000; e.res = a & b; end
         11'b10101010000: begin e.ctrl = 4'b0001; e.res = a | b; end
         11'b1001000100?: begin e.ctrl = 4'b0010; e.res = a + b; end
         11'b1101000100?: begin e.ctrl = 4'b0110; e.res = a - b; end
         11'b11111000010,
         11'b11111000000: begin e.ctrl = 4'b0010; e.res = a + b; end
         11'b10110100???: begin e.ctrl = 4'b0111; e.res = b; end
         default:         begin e.ill = 1'b1; e.res = 64'd0; end
      endcase
      e.zero = e.ill ? 1'b0 : (e.res == 64'd0);
      return e;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_tests++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic run_op(input int d, input logic [10:0] op, input logic [63:0] a,
                         input logic [63:0] b, input int hold);
      exp_t e;
      int   lat;
      e = ref_model(op, a, b);
      if (e.ill) begin
         e.lat = 1;
         e.ctrl = last_ctrl[d]; e.bus_a = last_a[d]; e.bus_b = last_b[d];
      end else begin
         e.lat = (d == 0) ? 2 : 4;
         last_ctrl[d] = e.ctrl; last_a[d] = a; last_b[d] = b;
      end
      sb.push_back(e);
      @(negedge clk);
      in_valid[d] = 1'b1; opcode[d] = op; op_a[d] = a; op_b[d] = b;
      chk("in_ready_idle", in_ready[d], 1);
      @(posedge clk); #1;
      in_valid[d] = 1'b0;
      opcode[d] = 11'($urandom); op_a[d] = {$urandom, $urandom}; op_b[d] = {$urandom, $urandom};
      lat = 1;
      while (!out_valid[d] && lat < 64) begin
         @(posedge clk); #1;
         lat++;
      end
      e = sb.pop_front();
      chk("latency", 64'(lat), 64'(e.lat));
      chk("result", result[d], e.res);
      chk("zero_flag", zero_flag[d], e.zero);
      chk("illegal", illegal[d], e.ill);
      chk("alu_ctrl", alu_ctrl[d], e.ctrl);
      chk("bus_a", bus_a[d], e.bus_a);
      chk("bus_b", bus_b[d], e.bus_b);
      chk("in_ready_resp", in_ready[d], 0);
      for (int i = 0; i < hold; i++) begin
         in_valid[d] = 1'b1; opcode[d] = 11'b10001011000;
         op_a[d] = {$urandom, $urandom}; op_b[d] = 64'd1;
         @(posedge clk); #1;
         chk("hold_valid", out_valid[d], 1);
         chk("hold_in_ready", in_ready[d], 0);
         chk("hold_result", result[d], e.res);
      end
      in_valid[d] = 1'b0;
      out_ready[d] = 1'b1;
      @(posedge clk); #1;
      out_ready[d] = 1'b0;
      exp_cnt[d]++;
      chk("out_valid_fall", out_valid[d], 0);
      chk("in_ready_back", in_ready[d], 1);
      chk("op_count", 64'(op_count[d]), 64'(exp_cnt[d]));
   endtask

   initial begin
      for (int d = 0; d < 2; d++) begin
         rst_n[d] = 1'b0; in_valid[d] = 1'b0; out_ready[d] = 1'b0;
         opcode[d] = 11'd0; op_a[d] = 64'd0; op_b[d] = 64'd0;
         exp_cnt[d] = 0; last_ctrl[d] = 4'b0000; last_a[d] = 64'd0; last_b[d] = 64'd0;
      end
      #1;
      for (int d = 0; d < 2; d++) begin
         chk("rst_in_ready", in_ready[d], 0);
         chk("rst_out_valid", out_valid[d], 0);
         chk("rst_alu_ctrl", alu_ctrl[d], 0);
         chk("rst_result", result[d], 0);
         chk("rst_op_count", 64'(op_count[d]), 0);
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n[0] = 1'b1; rst_n[1] = 1'b1;

      run_op(0, 11'b10001011000, 64'h5, 64'h3, 0);
      run_op(0, 11'b11001011000, 64'h7, 64'h7, 0);
      run_op(0, 11'b10101010000, 64'hF0, 64'h0F, 0);
      run_op(0, 11'b11111111111, 64'h1, 64'h2, 0);
      run_op(0, 11'b10001010000, 64'hFF00, 64'h0FF0, 5);
      run_op(0, 11'b11111000010, 64'h100, 64'h8, 0);
      run_op(0, 11'b10110100101, 64'h1234, 64'h0, 0);
      run_op(0, 11'b10010001001, 64'h10, 64'h20, 0);
      run_op(1, 11'b10010001000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 0);
      run_op(1, 11'b11010001001, 64'd10, 64'd3, 2);
      run_op(1, 11'b11111000000, 64'h2000, 64'h18, 0);

      // Reset pulse while an ADD sits in EXEC on the SETTLE=1 controller
      @(negedge clk);
      in_valid[0] = 1'b1; opcode[0] = 11'b10001011000; op_a[0] = 64'h9; op_b[0] = 64'h9;
      @(posedge clk); #1;
      in_valid[0] = 1'b0;
      chk("exec_no_valid", out_valid[0], 0);
      rst_n[0] = 1'b0;
      #1;
      chk("rst_exec_out_valid", out_valid[0], 0);
      chk("rst_exec_in_ready", in_ready[0], 0);
      chk("rst_exec_op_count", 64'(op_count[0]), 0);
      @(negedge clk);
      rst_n[0] = 1'b1;
      exp_cnt[0] = 0; last_ctrl[0] = 4'b0000; last_a[0] = 64'd0; last_b[0] = 64'd0;
      @(posedge clk); #1;
      chk("post_rst_out_valid", out_valid[0], 0);
      run_op(0, 11'b10001011000, 64'h5, 64'h3, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
